// File: rtl/button_bank.sv
// button_bank: synchronises, debounces and edge-detects CHANNELS active-low
// push-buttons.
//
// Build option: define BUTTON_REPEAT_EN to add per-channel auto-repeat on
// negative_edge_detected while a button is held. Without the macro the
// REPEAT_* parameters are ignored and no repeat logic is built.
//
// Ports:
//   clock                  system clock, rising edge
//   reset_n                asynchronous active-low reset
//   button_value           raw button pins (1 = released, 0 = pressed)
//   button_state           debounced level (1 = released, 0 = pressed)
//   negative_edge_detected one-cycle press pulse (plus repeats if enabled)
//   positive_edge_detected one-cycle release pulse
//   any_pressed            OR over channels of ~button_state
module button_bank #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 1000,
    parameter int unsigned REPEAT_PERIOD   = 250
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button_value,
    output logic [CHANNELS-1:0] button_state,
    output logic [CHANNELS-1:0] negative_edge_detected,
    output logic [CHANNELS-1:0] positive_edge_detected,
    output logic                any_pressed
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Elaboration-time parameter sanity check
    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_bank: all parameters must be >= 1");
    end

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] state_q;
    logic [CHANNELS-1:0] state_d;
    logic [CHANNELS-1:0] neg_q;
    logic [CHANNELS-1:0] neg_d;
    logic [CHANNELS-1:0] pos_q;
    logic [CHANNELS-1:0] pos_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rpt_fire;

    // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0]    rpt_q [CHANNELS];
    logic [RPT_W-1:0]    rpt_d [CHANNELS];
    logic [CHANNELS-1:0] armed_q;
    logic [CHANNELS-1:0] armed_d;
    logic [CHANNELS-1:0] press_c;

    assign press_c = state_q & ~state_d;

    // Auto-repeat: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD (armed_q set)
    always_comb begin
        rpt_d    = rpt_q;
        armed_d  = armed_q;
        rpt_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_d[i] || press_c[i]) begin
                // released, or the press pulse itself: restart the repeat timeline
                rpt_d[i]   = '0;
                armed_d[i] = 1'b0;
            end else if (rpt_q[i] == (armed_q[i] ? RPT_W'(REPEAT_PERIOD - 1)
                                                 : RPT_W'(REPEAT_DELAY - 1))) begin
                rpt_fire[i] = 1'b1;
                rpt_d[i]    = '0;
                armed_d[i]  = 1'b1;
            end else begin
                rpt_d[i] = rpt_q[i] + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_q[i] <= '0;
            end
        end else begin
            armed_q <= armed_d;
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_q[i] <= rpt_d[i];
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    // Pulses are registered alongside the state so they line up with the new level
    always_comb begin
        neg_d = (state_q & ~state_d) | rpt_fire;
        pos_d = ~state_q & state_d;
    end

    // Two-flop synchroniser, debounced state, counters and pulse registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= '1;
            neg_q   <= '0;
            pos_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= button_value;
            sync2_q <= sync1_q;
            state_q <= state_d;
            neg_q   <= neg_d;
            pos_q   <= pos_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign button_state           = state_q;
    assign negative_edge_detected = neg_q;
    assign positive_edge_detected = pos_q;
    assign any_pressed            = |(~state_q);

endmodule
